// File: rtl/mul_div_exec_ctrl_if.sv
// rtl/mul_div_exec_ctrl_if.sv - issue-queue and CDB signal bundle for the mul/div execution controller
interface mul_div_exec_ctrl_if;
  logic        issue_valid;
  logic [31:0] op1_data;
  logic [31:0] op2_data;
  logic [5:0]  rd_tag;
  logic        rd_tag_valid;
  logic [2:0]  funct3;
  logic        ex_done;
  logic        busy;
  logic        cdb_req;
  logic        cdb_grant;
  logic [5:0]  cdb_tag_out;
  logic [31:0] cdb_data_out;

  modport master (
    output issue_valid, op1_data, op2_data, rd_tag, rd_tag_valid, funct3, cdb_grant,
    input  ex_done, busy, cdb_req, cdb_tag_out, cdb_data_out
  );

  modport slave (
    input  issue_valid, op1_data, op2_data, rd_tag, rd_tag_valid, funct3, cdb_grant,
    output ex_done, busy, cdb_req, cdb_tag_out, cdb_data_out
  );
endinterface

// File: rtl/mul_div_exec_ctrl.sv
// rtl/mul_div_exec_ctrl.sv - RV32M sequencer: fixed-latency multiply, restoring divide, CDB hold
module mul_div_exec_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  mul_div_exec_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_funct3;
  logic [5:0]  r_tag;
  logic [31:0] r_op1, r_op2;
  logic [3:0]  r_mul_cnt;
  logic [4:0]  r_div_cnt;
  logic [31:0] r_rem, r_quo, r_dvs;
  logic        r_q_neg, r_r_neg;
  logic [31:0] r_cdb_data;
  logic [5:0]  r_cdb_tag;

  logic        w_capture;
  logic        w_in_signed;
  logic [31:0] w_abs1, w_abs2;
  logic        w_div_zero, w_div_ovf, w_special;
  logic [31:0] w_special_res;

  assign w_capture   = (r_state == S_IDLE) && bus.issue_valid && bus.rd_tag_valid && rst;
  assign w_in_signed = ~bus.funct3[0];
  assign w_abs1      = (w_in_signed && bus.op1_data[31]) ? (~bus.op1_data + 32'd1) : bus.op1_data;
  assign w_abs2      = (w_in_signed && bus.op2_data[31]) ? (~bus.op2_data + 32'd1) : bus.op2_data;

  // Divide corner cases never enter the iterative loop; their result is known at capture.
  assign w_div_zero  = (bus.op2_data == 32'd0);
  assign w_div_ovf   = w_in_signed && (bus.op1_data == 32'h8000_0000) && (bus.op2_data == 32'hFFFF_FFFF);
  assign w_special   = bus.funct3[2] && (w_div_zero || w_div_ovf);
  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero)
      w_special_res = bus.funct3[1] ? bus.op1_data : 32'hFFFF_FFFF;
    else
      w_special_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  logic        w_a_signed, w_b_signed;
  logic [63:0] w_a64, w_b64, w_prod;
  logic [31:0] w_mul_res;

  assign w_a_signed = (r_funct3[1:0] != 2'b11) && r_op1[31];
  assign w_b_signed = ~r_funct3[1] && r_op2[31];
  assign w_a64      = {{32{w_a_signed}}, r_op1};
  assign w_b64      = {{32{w_b_signed}}, r_op2};
  assign w_prod     = w_a64 * w_b64;
  assign w_mul_res  = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  logic [32:0] w_shift, w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next, w_quo_next, w_div_res;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[32];
  assign w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_qbit};
  assign w_div_res  = r_funct3[1] ? (r_r_neg ? (~w_rem_next + 32'd1) : w_rem_next)
                                  : (r_q_neg ? (~w_quo_next + 32'd1) : w_quo_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          if (!bus.funct3[2])
            w_next = S_MUL;
          else if (w_special)
            w_next = S_DONE;
          else
            w_next = S_DIV;
        end
      end
      S_MUL:   if (r_mul_cnt == 4'd0) w_next = S_DONE;
      S_DIV:   if (r_div_cnt == 5'd0) w_next = S_DONE;
      S_DONE:  if (bus.cdb_grant)     w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_funct3   <= 3'd0;
      r_tag      <= 6'd0;
      r_op1      <= 32'd0;
      r_op2      <= 32'd0;
      r_mul_cnt  <= 4'd0;
      r_div_cnt  <= 5'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_dvs      <= 32'd0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_cdb_data <= 32'd0;
      r_cdb_tag  <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_funct3  <= bus.funct3;
            r_tag     <= bus.rd_tag;
            r_op1     <= bus.op1_data;
            r_op2     <= bus.op2_data;
            r_mul_cnt <= 4'(MUL_CYCLES - 1);
            r_div_cnt <= 5'd31;
            r_rem     <= 32'd0;
            r_quo     <= w_abs1;
            r_dvs     <= w_abs2;
            r_q_neg   <= w_in_signed && (bus.op1_data[31] ^ bus.op2_data[31]);
            r_r_neg   <= w_in_signed && bus.op1_data[31];
            if (w_special) begin
              r_cdb_data <= w_special_res;
              r_cdb_tag  <= bus.rd_tag;
            end
          end
        end
        S_MUL: begin
          if (r_mul_cnt == 4'd0) begin
            r_cdb_data <= w_mul_res;
            r_cdb_tag  <= r_tag;
          end else begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_div_cnt == 5'd0) begin
            r_cdb_data <= w_div_res;
            r_cdb_tag  <= r_tag;
          end else begin
            r_div_cnt <= r_div_cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ex_done      = w_capture;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.cdb_req      = (r_state == S_DONE);
  assign bus.cdb_tag_out  = r_cdb_tag;
  assign bus.cdb_data_out = r_cdb_data;

endmodule
